// File: rtl/fsm_step_arbiter.sv
// fsm_step_arbiter: shares one stepping 16-state control FSM between two requesters.
// A granted requester gets an optional synchronous clear followed by len steps of a
// fixed steering pattern. The FSM state is then returned in result with a done pulse.
//
// Ports:
//   clk, reset_n                 clock (rising edge), asynchronous active-low reset
//   req0/1, in1_x, in2_x         per-requester request and steering pattern
//   len0/1, clr0/1               per-requester step count and clear-first flag
//   gnt0/1, done0/1              one-cycle accept / completion pulses
//   result                       FSM state captured at burst end, held until next capture
//   state_in                     current state of the shared FSM
//   step_en, fsm_in1/2           FSM advance enable and steering inputs
//   fsm_clear                    synchronous clear to the FSM
module fsm_step_arbiter #(
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             in1_0,
    input  logic             in2_0,
    input  logic             in1_1,
    input  logic             in2_1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic             clr0,
    input  logic             clr1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [3:0]       result,
    input  logic [3:0]       state_in,
    output logic             step_en,
    output logic             fsm_in1,
    output logic             fsm_in2,
    output logic             fsm_clear
);

    typedef enum logic [1:0] {StIdle, StClr, StStep, StFin} state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_grant_q, last_grant_d;
    logic               pat1_q, pat1_d;
    logic               pat2_q, pat2_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic               done0_q, done0_d;
    logic               done1_q, done1_d;
    logic [3:0]         result_q, result_d;

    logic               win;
    logic [LEN_W-1:0]   sel_len;
    logic               sel_clr;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        pat1_d       = pat1_q;
        pat2_d       = pat2_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        result_d     = result_q;

        // On a tie the requester that did not win last time goes first.
        win     = (req0 && req1) ? ~last_grant_q : req1;
        sel_len = win ? len1 : len0;
        sel_clr = win ? clr1 : clr0;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    owner_d      = win;
                    last_grant_d = win;
                    pat1_d       = win ? in1_1 : in1_0;
                    pat2_d       = win ? in2_1 : in2_0;
                    len_d        = sel_len;
                    // Counter is preloaded here so CLR can hand over to STEP directly.
                    cnt_d        = sel_len;
                    gnt0_d       = ~win;
                    gnt1_d       = win;
                    if (sel_clr) begin
                        state_d = StClr;
                    end else if (sel_len != '0) begin
                        state_d = StStep;
                    end else begin
                        state_d = StFin;
                    end
                end
            end
            StClr: begin
                state_d = (len_q != '0) ? StStep : StFin;
            end
            StStep: begin
                cnt_d = cnt_q - LEN_W'(1);
                if (cnt_q <= LEN_W'(1)) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                result_d = state_in;
                done0_d  = ~owner_q;
                done1_d  = owner_q;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            pat1_q       <= 1'b0;
            pat2_q       <= 1'b0;
            len_q        <= '0;
            cnt_q        <= '0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            result_q     <= 4'h0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            pat1_q       <= pat1_d;
            pat2_q       <= pat2_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            result_q     <= result_d;
        end
    end

    // FSM-facing controls decode the state register only, so reset drops them at once.
    assign step_en   = (state_q == StStep);
    assign fsm_clear = (state_q == StClr);
    assign fsm_in1   = step_en & pat1_q;
    assign fsm_in2   = step_en & pat2_q;

    assign gnt0   = gnt0_q;
    assign gnt1   = gnt1_q;
    assign done0  = done0_q;
    assign done1  = done1_q;
    assign result = result_q;

endmodule

// File: tb/tb_fsm_step_arbiter.sv
// Bench for fsm_step_arbiter: models the shared FSM, drives bursts from a vector table
// and hand-written sequences, and checks gnt/done timing and result via event queues.
module tb_fsm_step_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic       in1_0 = 1'b0, in2_0 = 1'b0, in1_1 = 1'b0, in2_1 = 1'b0;
    logic [3:0] len0 = 4'd0, len1 = 4'd0;
    logic       clr0 = 1'b0, clr1 = 1'b0;
    logic       gnt0, gnt1, done0, done1;
    logic [3:0] result;
    logic [3:0] state_in;
    logic       step_en, fsm_in1, fsm_in2, fsm_clear;

    fsm_step_arbiter #(.LEN_W(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0      (req0),
        .req1      (req1),
        .in1_0     (in1_0),
        .in2_0     (in2_0),
        .in1_1     (in1_1),
        .in2_1     (in2_1),
        .len0      (len0),
        .len1      (len1),
        .clr0      (clr0),
        .clr1      (clr1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .result    (result),
        .state_in  (state_in),
        .step_en   (step_en),
        .fsm_in1   (fsm_in1),
        .fsm_in2   (fsm_in2),
        .fsm_clear (fsm_clear)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared control FSM sitting behind the arbiter.
    function automatic logic [3:0] fsm_next(input logic [3:0] s, input logic a, input logic b);
        logic [3:0] n;
        case (s[2:0])
            3'd0:    n = (a && b)   ? 4'h1 : 4'h2;
            3'd1:    n = (!a && b)  ? 4'h3 : 4'h4;
            3'd2:    n = (a && !b)  ? 4'h5 : 4'h6;
            3'd3:    n = (!a && !b) ? 4'h7 : 4'h8;
            3'd4:    n = (a || b)   ? 4'h9 : 4'hA;
            3'd5:    n = (!a || b)  ? 4'hB : 4'hC;
            3'd6:    n = (a || !b)  ? 4'hD : 4'hE;
            default: n = (!a || !b) ? 4'hF : 4'h0;
        endcase
        return n;
    endfunction

    logic [3:0] fsm_q;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)       fsm_q <= 4'h0;
        else if (fsm_clear) fsm_q <= 4'h0;
        else if (step_en)   fsm_q <= fsm_next(fsm_q, fsm_in1, fsm_in2);
    end
    assign state_in = fsm_q;

    typedef struct {
        logic       who;
        logic [3:0] res;
        int         cyc;
    } ev_t;

    typedef struct {
        logic       who;
        logic       i1;
        logic       i2;
        logic [3:0] len;
        logic       clr;
        logic [3:0] res;
        int         lat;
    } vec_t;

    ev_t  gq[$];
    ev_t  dq[$];
    ev_t  eg, ed;
    vec_t tbl[9];
    logic [3:0] ctl_exp[6];
    int checks = 0;
    int errors = 0;
    int c0;

    task automatic push_gnt(input logic who, input int at);
        ev_t e;
        e.who = who; e.res = 4'h0; e.cyc = at;
        gq.push_back(e);
    endtask

    task automatic push_done(input logic who, input logic [3:0] res, input int at);
        ev_t e;
        e.who = who; e.res = res; e.cyc = at;
        dq.push_back(e);
    endtask

    task automatic drive(input logic who, input logic i1, input logic i2,
                         input logic [3:0] len, input logic clr);
        if (who) begin
            in1_1 = i1; in2_1 = i2; len1 = len; clr1 = clr; req1 = 1'b1;
        end else begin
            in1_0 = i1; in2_0 = i2; len0 = len; clr0 = clr; req0 = 1'b1;
        end
    endtask

    // Waits for the requester's gnt and drops its req in the same cycle.
    task automatic wait_gnt(input logic who);
        bit seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (who ? gnt1 : gnt0) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL gnt_timeout who=%0d actual=none required=gnt within 60 cycles", who);
        end
        if (who) req1 = 1'b0; else req0 = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 80 && (gq.size() != 0 || dq.size() != 0); n++) @(negedge clk);
        if (gq.size() != 0 || dq.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d/%0d pending required=0/0",
                     gq.size(), dq.size());
        end
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b1, 1'b0, 4'd2,  1'b0, 4'hC, 4};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 4'd3,  1'b0, 4'h8, 5};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 4'd1,  1'b1, 4'h1, 4};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 4'd4,  1'b0, 4'hD, 6};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 4'hD, 2};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 4'd0,  1'b1, 4'h0, 3};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 4'd15, 1'b1, 4'h9, 18};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 4'd2,  1'b0, 4'h9, 4};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 4'd1,  1'b0, 4'h4, 3};
        // {fsm_clear, step_en, fsm_in1, fsm_in2} for cycles 1..5 of a cleared len=3 burst
        ctl_exp[0] = 4'b0000; ctl_exp[1] = 4'b1000; ctl_exp[2] = 4'b0111;
        ctl_exp[3] = 4'b0111; ctl_exp[4] = 4'b0111; ctl_exp[5] = 4'b0000;

        // Reset with random inputs: every output must stay low.
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            {req0, req1, in1_0, in2_0, in1_1, in2_1, clr0, clr1} = 8'($urandom);
            len0 = 4'($urandom); len1 = 4'($urandom);
            @(negedge clk);
            checks++;
            if ({gnt0, gnt1, done0, done1, step_en, fsm_in1, fsm_in2, fsm_clear} != 8'h0
                || result != 4'h0) begin
                errors++;
                $display("FAIL reset_outputs actual=%b result=%h required=0 result=0",
                         {gnt0, gnt1, done0, done1, step_en, fsm_in1, fsm_in2, fsm_clear},
                         result);
            end
        end
        {req0, req1, in1_0, in2_0, in1_1, in2_1, clr0, clr1} = 8'h0;
        len0 = 4'd0; len1 = 4'd0;
        reset_n = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (reset_n) begin
                    while (gq.size() > 0 && gq[0].cyc < cyc) begin
                        eg = gq.pop_front();
                        checks++; errors++;
                        $display("FAIL gnt_missing who=%0d actual=none required_cycle=%0d",
                                 eg.who, eg.cyc);
                    end
                    while (dq.size() > 0 && dq[0].cyc < cyc) begin
                        ed = dq.pop_front();
                        checks++; errors++;
                        $display("FAIL done_missing who=%0d actual=none required_cycle=%0d",
                                 ed.who, ed.cyc);
                    end
                    if (gnt0 || gnt1) begin
                        checks++;
                        if (gq.size() == 0) begin
                            errors++;
                            $display("FAIL gnt_unexpected actual=%b%b cycle=%0d required=none",
                                     gnt0, gnt1, cyc);
                        end else begin
                            eg = gq.pop_front();
                            if (eg.cyc != cyc || gnt1 != eg.who || gnt0 == eg.who) begin
                                errors++;
                                $display("FAIL gnt actual=gnt0:%b gnt1:%b cycle=%0d required=who%0d cycle=%0d",
                                         gnt0, gnt1, cyc, eg.who, eg.cyc);
                            end
                        end
                    end
                    if (done0 || done1) begin
                        checks++;
                        if (dq.size() == 0) begin
                            errors++;
                            $display("FAIL done_unexpected actual=%b%b cycle=%0d required=none",
                                     done0, done1, cyc);
                        end else begin
                            ed = dq.pop_front();
                            if (ed.cyc != cyc || done1 != ed.who || done0 == ed.who
                                || result != ed.res) begin
                                errors++;
                                $display("FAIL done actual=d0:%b d1:%b res=%h cycle=%0d required=who%0d res=%h cycle=%0d",
                                         done0, done1, result, cyc, ed.who, ed.res, ed.cyc);
                            end
                        end
                    end
                    if ((!step_en && (fsm_in1 || fsm_in2)) || (step_en && fsm_clear)) begin
                        checks++; errors++;
                        $display("FAIL fsm_ctl actual=clr:%b en:%b in:%b%b required=quiet inputs",
                                 fsm_clear, step_en, fsm_in1, fsm_in2);
                    end
                end
            end
        join_none

        // Tie after reset: requester 0 first (in=11 len=3 clr), then requester 1 (00, len 2).
        @(posedge clk); #1;
        c0 = cyc;
        drive(1'b0, 1'b1, 1'b1, 4'd3, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 4'd2, 1'b0);
        push_gnt(1'b0, c0 + 1);  push_done(1'b0, 4'h9, c0 + 6);
        push_gnt(1'b1, c0 + 7);  push_done(1'b1, 4'hA, c0 + 10);
        @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if ({fsm_clear, step_en, fsm_in1, fsm_in2} != ctl_exp[k]) begin
                errors++;
                $display("FAIL clr_step_seq cycle=%0d actual=%b required=%b",
                         k, {fsm_clear, step_en, fsm_in1, fsm_in2}, ctl_exp[k]);
            end
            if (k == 1) req0 = 1'b0;
        end
        wait_gnt(1'b1);
        wait_idle();

        // Table of single-requester bursts, chained through the shared FSM state.
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            c0 = cyc;
            drive(tbl[i].who, tbl[i].i1, tbl[i].i2, tbl[i].len, tbl[i].clr);
            push_gnt(tbl[i].who, c0 + 1);
            push_done(tbl[i].who, tbl[i].res, c0 + tbl[i].lat);
            wait_gnt(tbl[i].who);
            wait_idle();
        end

        // Both held continuously with len=1: grants alternate 0,1,0,1.
        @(posedge clk); #1;
        c0 = cyc;
        drive(1'b0, 1'b1, 1'b1, 4'd1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            push_gnt(1'(k % 2), c0 + 1 + 3 * k);
            push_done(1'(k % 2), (k % 2 == 0) ? 4'h9 : 4'h4, c0 + 3 + 3 * k);
        end
        repeat (11) @(posedge clk);
        #1;
        req0 = 1'b0; req1 = 1'b0;
        wait_idle();

        // Reset in step cycle 3 of a len=5 burst: controls drop at once, no done.
        @(posedge clk); #1;
        c0 = cyc;
        drive(1'b0, 1'b0, 1'b0, 4'd5, 1'b0);
        push_gnt(1'b0, c0 + 1);
        wait_gnt(1'b0);
        @(posedge clk); @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({step_en, fsm_in1, fsm_in2, fsm_clear, gnt0, gnt1, done0, done1} != 8'h0
            || result != 4'h0) begin
            errors++;
            $display("FAIL reset_midburst actual=%b result=%h required=0 result=0",
                     {step_en, fsm_in1, fsm_in2, fsm_clear, gnt0, gnt1, done0, done1}, result);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);

        // First tie after reset goes to requester 0 again.
        @(posedge clk); #1;
        c0 = cyc;
        drive(1'b0, 1'b1, 1'b1, 4'd1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
        push_gnt(1'b0, c0 + 1);  push_done(1'b0, 4'h1, c0 + 3);
        push_gnt(1'b1, c0 + 4);  push_done(1'b1, 4'h4, c0 + 6);
        wait_gnt(1'b0);
        wait_gnt(1'b1);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
